ps2_device_tx: RTL and testbench

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_device_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_device_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes in a 4-deep FIFO and
// shifts each out as an 11-bit frame, backing off when the host inhibits the clock.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 5,
  parameter int GAP_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam int CNT_MAX = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     frame_q, frame_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [1:0]      sync_q, sync_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic [7:0]      mem_q [4];

  logic       inh_n;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign inh_n = sync_q[1];
  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign push  = din_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    sync_d   = {sync_q[0], ps2_clk_in};
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push) - 3'(pop);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && inh_n) begin
          state_d   = HIGH;
          cnt_d     = HP_LOAD;
          frame_d   = {1'b1, ~^head, head, 1'b0};
          bit_cnt_d = 4'd0;
        end
      end
      HIGH: begin
        // A low sensed clock while we release it high means the host is inhibiting.
        if (!inh_n) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = HP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (bit_cnt_q < 4'd10) begin
            state_d   = HIGH;
            cnt_d     = HP_LOAD;
            frame_d   = {1'b1, frame_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            done_d  = 1'b1;
            pop     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '1;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      sync_q    <= 2'b11;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      sync_q    <= sync_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign din_ready   = !full;
  assign ps2_clk     = (state_q != LOW);
  assign ps2_data    = (state_q == HIGH || state_q == LOW) ? frame_q[0] : 1'b1;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a line monitor rebuilds frames and timing,
// the main sequence drives a byte table plus inhibit, backlog and reset cases.
module tb_ps2_device_tx;

  localparam int HP  = 5;
  localparam int GAP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/missing required event", name);
  endtask

  // Line monitor, sampled on the falling system-clock edge.
  logic [10:0] frames_q[$];
  int          lens_q[$];
  int          gaps_q[$];
  int          aborts = 0;
  logic        prev_clk = 1'b1;
  logic        held = 1'b1;
  logic        in_gap = 1'b0;
  logic [10:0] bitvec = '0;
  int          low_run = 0, cyc = 0, last_fall = 0, nbits = 0, act = 0, gap_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_clk = 1'b1; low_run = 0; nbits = 0; act = 0; in_gap = 1'b0; gap_run = 0;
    end else begin
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0) check("bit_period", cyc - last_fall, 2 * HP);
        last_fall = cyc;
        held = ps2_data;
        if (nbits < 11) bitvec[nbits] = ps2_data;
        nbits++;
      end
      if (!ps2_clk) begin
        low_run++;
        check("data_hold_low", ps2_data, held);
      end else if (!prev_clk) begin
        check("low_len", low_run, HP);
        low_run = 0;
      end
      prev_clk = ps2_clk;
      if (frame_done) begin
        check("bits_per_frame", nbits, 11);
        frames_q.push_back(bitvec);
        lens_q.push_back(act);
        nbits = 0; in_gap = 1'b1; gap_run = 0;
      end
      if (frame_abort) begin
        aborts++;
        nbits = 0; in_gap = 1'b1; gap_run = 0;
      end
      if (busy) act++; else act = 0;
      if (in_gap) begin
        if (busy) gap_run++;
        else begin gaps_q.push_back(gap_run); in_gap = 1'b0; end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    while (!din_ready && n < 2000) begin @(negedge clk); n++; end
    if (!din_ready) fail_now("push_ready");
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_q.size() < n && t < 3000) begin @(negedge clk); t++; end
    if (frames_q.size() < n) fail_now("frame_wait");
  endtask

  task automatic wait_busy();
    int t;
    t = 0;
    while (!busy && t < 100) begin @(negedge clk); t++; end
    if (!busy) fail_now("busy_wait");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    if (busy) fail_now("idle_wait");
    @(negedge clk);
  endtask

  task automatic check_frame(input logic [7:0] b, input logic [10:0] exp);
    logic [10:0] f;
    if (frames_q.size() == 0) fail_now("frame_missing");
    else begin
      f = frames_q.pop_front();
      $display("frame byte %02h: bits %03h expected %03h", b, f, exp);
      check("frame_bits", 32'(f), 32'(exp));
    end
  endtask

  task automatic check_len(input int exp);
    if (lens_q.size() == 0) fail_now("len_missing");
    else check("frame_len", lens_q.pop_front(), exp);
  endtask

  task automatic check_gap(input int exp);
    if (gaps_q.size() == 0) fail_now("gap_missing");
    else check("gap_len", gaps_q.pop_front(), exp);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [10:0] frame;  // bit 0 = first bit on the wire (start)
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic seen;
    // Hand-computed frames {stop, odd parity, data, start}.
    vecs[0] = '{din: 8'h1C, frame: 11'h438};
    vecs[1] = '{din: 8'hFF, frame: 11'h7FE};
    vecs[2] = '{din: 8'h00, frame: 11'h600};
    vecs[3] = '{din: 8'h01, frame: 11'h402};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", ps2_clk, 1'b1);
    check("rst_ps2_data", ps2_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_abort", frame_abort, 1'b0);
    rst_n = 1'b1;

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].din);
      wait_frames(1);
      check_frame(vecs[i].din, vecs[i].frame);
      wait_idle();
      check_len(11 * 2 * HP);
      check_gap(GAP);
    end

    // Backlog while the host inhibits: four fill the FIFO, the fifth waits for a pop.
    @(negedge clk);
    ps2_clk_in = 1'b0;
    repeat (2) @(negedge clk);
    push(8'hF0); push(8'h1C); push(8'hAA); push(8'h55);
    @(negedge clk);
    check("full_din_ready", din_ready, 1'b0);
    check("inhibit_busy", busy, 1'b0);
    check("inhibit_clk", ps2_clk, 1'b1);
    din = 8'h12;
    din_valid = 1'b1;
    ps2_clk_in = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("release_latency", n, 3);
    n = 0;
    while (!din_ready && n < 1000) begin @(negedge clk); n++; end
    check("accept_at_pop", frame_done, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    wait_frames(5);
    check_frame(8'hF0, 11'h7E0);
    check_frame(8'h1C, 11'h438);
    check_frame(8'hAA, 11'h754);
    check_frame(8'h55, 11'h6AA);
    check_frame(8'h12, 11'h624);
    wait_idle();
    lens_q.delete();
    gaps_q.delete();

    // Host inhibit during HIGH of bit 4, then full resend.
    push(8'h1C);
    wait_busy();
    repeat (41) @(negedge clk);
    ps2_clk_in = 1'b0;
    n = 0;
    while (!frame_abort && n < 20) begin @(negedge clk); n++; end
    check("abort_delay", n, 3);
    check("abort_clk_high", ps2_clk, 1'b1);
    check("abort_data_high", ps2_data, 1'b1);
    check("abort_no_done", frames_q.size(), 0);
    repeat (7) @(negedge clk);
    ps2_clk_in = 1'b1;
    wait_frames(1);
    check_frame(8'h1C, 11'h438);
    check("abort_count", aborts, 1);
    wait_idle();
    check_len(11 * 2 * HP);
    check_gap(GAP);
    check_gap(GAP);

    // Reset in the middle of a frame with bytes still queued.
    push(8'h55);
    wait_busy();
    push(8'hAA);
    push(8'h12);
    n = 0;
    while ((ps2_clk || ps2_data) && n < 200) begin @(negedge clk); n++; end
    check("pre_reset_clk_low", ps2_clk, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk", ps2_clk, 1'b1);
    check("async_rst_data", ps2_data, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", din_ready, 1'b1);
    check("async_rst_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy || frame_done) seen = 1'b1;
    end
    check("post_reset_quiet", seen, 1'b0);
    check("post_reset_frames", frames_q.size(), 0);
    check("post_reset_ready", din_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
